// File: rtl/dac_wave_player.sv
`default_nettype none
// ============================================================================
// Module   : dac_wave_player
// Purpose  : Sample buffer plus playback sequencer for a parallel-input DAC.
//            Samples are appended while idle, then streamed to the DAC at a
//            fixed sample period (DIV clocks) in loop or one-shot mode, with
//            the DAC write / load / reset strobes generated alongside.
// Revision : 1.0 - initial release
// ============================================================================
module dac_wave_player #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DIV    = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_we_n,
    output logic              dac_ldac_n,
    output logic              dac_rst_n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] play_addr
);

    localparam int                 c_DEPTH    = 1 << ADDR_W;
    localparam int                 c_DIV_W    = $clog2(DIV);
    localparam logic [ADDR_W:0]    c_LEN_FULL = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0]    c_LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV-1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE = ADDR_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PRIME = 2'd1;
    localparam logic [1:0] c_PLAY  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [c_DIV_W-1:0] r_div;
    logic               r_loop;
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  r_dac_data;
    logic [ADDR_W-1:0]  r_play_addr;
    logic               r_we_n;
    logic               r_ldac_n;
    logic               r_rst_n;
    logic               r_done;

    logic               w_idle;
    logic               w_wr_fire;
    logic               w_start_ok;
    logic               w_tick;
    logic               w_last;
    logic [ADDR_W-1:0]  w_ram_addr;

    assign w_idle     = (r_state == c_IDLE);
    assign wr_ready   = !reset && w_idle && (r_len < c_LEN_FULL) && !start && !clear;
    assign w_wr_fire  = wr_valid && wr_ready;
    // clear beats start; an empty buffer never starts playback
    assign w_start_ok = w_idle && start && !clear && (r_len != '0);
    assign w_tick     = (r_state == c_PLAY) && (r_div == c_DIV_LAST);
    assign w_last     = ({1'b0, r_rd_addr} == (r_len - c_LEN_ONE));
    // single port: the append pointer while idle, the playback pointer otherwise
    assign w_ram_addr = w_idle ? r_len[ADDR_W-1:0] : r_rd_addr;

    // Sample RAM: write on accepted append, read every cycle (prefetch)
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_ram_addr] <= wr_data;
        end
        r_rd_data <= r_mem[w_ram_addr];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_ok) w_state_nxt = c_PRIME;
            c_PRIME: w_state_nxt = stop ? c_IDLE : c_PLAY;
            c_PLAY:  if (stop || (w_tick && w_last && !r_loop)) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Buffer length, sample-period divider, read pointer and DAC data path
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= '0;
            r_rd_addr   <= '0;
            r_div       <= '0;
            r_loop      <= 1'b0;
            r_dac_data  <= '0;
            r_play_addr <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_idle) begin
                r_div <= '0;
                if (clear) begin
                    r_len <= '0;
                end else if (w_wr_fire) begin
                    r_len <= r_len + c_LEN_ONE;
                end
                if (w_start_ok) begin
                    r_rd_addr <= '0;
                    r_loop    <= loop_mode;
                end
            end else begin
                r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_ONE;
            end
            // a tick presents the prefetched sample and issues the next read
            if (w_tick) begin
                r_dac_data  <= r_rd_data;
                r_play_addr <= r_rd_addr;
                r_rd_addr   <= w_last ? '0 : r_rd_addr + c_ADDR_ONE;
                if (w_last && !r_loop) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Strobe shifter: write strobe after a tick, load strobe one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we_n   <= 1'b1;
            r_ldac_n <= 1'b1;
        end else begin
            r_we_n   <= !w_tick;
            r_ldac_n <= r_we_n;
        end
    end

    // DAC reset follows the system reset delayed by one clock
    always_ff @(posedge clk) begin
        r_rst_n <= !reset;
    end

    assign dac_data   = r_dac_data;
    assign dac_we_n   = r_we_n;
    assign dac_ldac_n = r_ldac_n;
    assign dac_rst_n  = r_rst_n;
    assign busy       = !w_idle;
    assign done       = r_done;
    assign len        = r_len;
    assign play_addr  = r_play_addr;

endmodule
`default_nettype wire

// File: doc/dac_wave_player.md
Name: dac_wave_player

Overview:
- Parametrised sample buffer and playback sequencer feeding a parallel-input DAC.
- Samples are appended through a valid/ready write port while idle. The stored waveform is then streamed to the DAC at a programmable sample period, in loop or one-shot mode.
- Generates the DAC write, load and reset strobes. Sits between the host data path and the DAC pins.

Parameters:
- DATA_W, 16, sample and DAC bus width.
- ADDR_W, 16, buffer address width; DEPTH = 2**ADDR_W samples.
- DIV, 17, sample period in clk cycles; must be >= 3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_data  in  DATA_W  sample to append.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- clear  in  1  empty the buffer (honoured in IDLE only).
- start  in  1  begin playback (honoured in IDLE only).
- stop  in  1  abort playback.
- loop_mode  in  1  1 = loop, 0 = one-shot; sampled when start is accepted.
- dac_data  out  DATA_W  DAC data bus.
- dac_we_n  out  1  DAC write strobe, active low.
- dac_ldac_n  out  1  DAC load strobe, active low.
- dac_rst_n  out  1  DAC reset, active low.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at one-shot completion.
- len  out  ADDR_W+1  number of stored samples, 0..DEPTH.
- play_addr  out  ADDR_W  address of the sample most recently driven on dac_data.

Behaviour:
- **Reset values:** state IDLE, len 0, dac_data 0, dac_we_n 1, dac_ldac_n 1, dac_rst_n 0, busy 0, done 0, play_addr 0, divider 0. wr_ready is 0 while reset is high.
- **dac_rst_n:** registered ~reset; it rises on the first edge after reset deasserts.
- **Buffer:** single-port synchronous RAM, one-cycle read latency, no reset of contents.
- **wr_ready:** = !reset && state==IDLE && len<DEPTH && !start && !clear.
- **Accepted write:** mem[len] <= wr_data; len <= len+1. When len==DEPTH, wr_ready is 0 and further writes stall.
- **clear in IDLE:** len <= 0. Same cycle as start: clear wins and start is ignored. Ignored outside IDLE.
- **start in IDLE with len==0:** ignored; busy stays 0.

State machine:
- IDLE -> PRIME on start with len>0. On that edge: divider <= 0, rd_addr <= 0, mode latched.
- PRIME: one cycle for the RAM read of address 0, then PLAY. The divider counts through PRIME.
- PLAY: divider counts 0..DIV-1 and wraps. A tick occurs on the edge where divider==DIV-1.
  - On a tick: dac_data <= prefetched sample; play_addr <= rd_addr; the next address is issued (rd_addr+1, or 0 after len-1 when in loop mode).
  - The first tick is the DIV-th rising edge after the edge that accepted start.
- **Strobe sequence:** independent 2-stage shift register launched by each tick.
  - dac_we_n is low for exactly the 1 cycle following the tick edge.
  - dac_ldac_n is low for exactly the following cycle.
  - Because DIV >= 3, sequences never overlap.
  - A sequence already launched always completes, even if state leaves PLAY.
- **One-shot end:** on the tick presenting address len-1, state -> IDLE and done = 1 for the next cycle only.
  - dac_data holds the last sample.
  - No further ticks occur.
- **Loop mode:** wraps from address len-1 to 0 without a gap; the period is exactly DIV cycles.
- **stop in PRIME/PLAY:** state -> IDLE on that edge; no done pulse; dac_data holds its value.
  - If stop coincides with a tick, the tick completes first (its dac_data update and strobes occur), then state goes to IDLE.
  - stop in IDLE has no effect.
- **reset mid-playback:** immediate return to the reset values. In-flight strobes are cancelled (dac_we_n and dac_ldac_n go to 1). len goes to 0.

Test Plan:
- **Reset:** assert reset 3 cycles mid-operation -> dac_we_n=1, dac_ldac_n=1, dac_rst_n=0, busy=0, len=0; dac_rst_n=1 one cycle after release.
- **Loop:** DIV=4. Load 0000, 5555, AAAA; loop_mode=1; start.
  - dac_data = 0000, 5555, AAAA, 0000, 5555 at edges T+4, T+8, T+12, T+16, T+20.
  - dac_we_n low at the cycle after each update; dac_ldac_n low the cycle after that.
- **One-shot:** same data, loop_mode=0 -> exactly 3 updates; done high 1 cycle after the AAAA tick; busy=0; dac_data stays AAAA; no more strobes.
- **Full buffer:** ADDR_W=3; stream 9 writes -> 8 accepted, wr_ready=0 at len=8, 9th held.
  - start plays addresses 0..7 in order.
- **Control corners:**
  - start with len=0 -> busy stays 0.
  - clear+start together -> len=0, busy=0.
  - stop on a tick cycle -> that sample and its strobes are issued, then busy=0.
- **Restart:** after stop, writes are accepted again, appending at the old len; a new start begins at address 0.
